// File: rtl/alu_pkg.sv
// Shared ALU control encodings, DLX opcode/func constants and the issue-stage entry type.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SEQ = 4'b0001;
    localparam logic [3:0] ALU_SNE = 4'b1001;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SGT = 4'b0011;
    localparam logic [3:0] ALU_SLE = 4'b1101;
    localparam logic [3:0] ALU_SGE = 4'b1011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SGTI  = 6'h1B;
    localparam logic [5:0] OP_SLEI  = 6'h1C;
    localparam logic [5:0] OP_SGEI  = 6'h1D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SEQ = 6'h28;
    localparam logic [5:0] FN_SNE = 6'h29;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SGT = 6'h2B;
    localparam logic [5:0] FN_SLE = 6'h2C;
    localparam logic [5:0] FN_SGE = 6'h2D;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] in1;
        logic [ALU_DATA_W-1:0] in2;
        logic [3:0]            crtlSig;
        logic                  illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational DLX opcode/func decode into ALU control, immediate select and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] crtlSig,
    output logic       imm_sel,
    output logic       illegal
);

    always_comb begin
        crtlSig = ALU_ADD;
        imm_sel = 1'b0;
        illegal = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (func)
                FN_ADD:  crtlSig = ALU_ADD;
                FN_SEQ:  crtlSig = ALU_SEQ;
                FN_SNE:  crtlSig = ALU_SNE;
                FN_SLT:  crtlSig = ALU_SLT;
                FN_SGT:  crtlSig = ALU_SGT;
                FN_SLE:  crtlSig = ALU_SLE;
                FN_SGE:  crtlSig = ALU_SGE;
                default: illegal = 1'b1;
            endcase
        end else begin
            imm_sel = 1'b1;
            case (opcode)
                OP_ADDI: crtlSig = ALU_ADD;
                OP_SEQI: crtlSig = ALU_SEQ;
                OP_SNEI: crtlSig = ALU_SNE;
                OP_SLTI: crtlSig = ALU_SLT;
                OP_SGTI: crtlSig = ALU_SGT;
                OP_SLEI: crtlSig = ALU_SLE;
                OP_SGEI: crtlSig = ALU_SGE;
                default: begin
                    // Unknown opcodes still issue, as an ADD on the register operands.
                    imm_sel = 1'b0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage issue register with a 2-entry (output + skid) valid/ready buffer feeding alu_arith.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_CNT_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] rs1_val,
    input  logic [DATA_W-1:0] rs2_val,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [3:0]        crtlSig,
    output logic              illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]       issue_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic [3:0]        dec_crtl;
    logic              dec_imm_sel;
    logic              dec_illegal;
    logic [DATA_W-1:0] imm_ext;

    // Entry storage uses alu_entry_t, so DATA_W is expected to equal ALU_DATA_W.
    alu_entry_t new_entry;
    alu_entry_t out_q;
    alu_entry_t out_d;
    alu_entry_t skid_q;
    alu_entry_t skid_d;
    logic       out_valid_d;
    logic       skid_full_q;
    logic       skid_full_d;
    logic       accept;
    logic       issue;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .func    (func),
        .crtlSig (dec_crtl),
        .imm_sel (dec_imm_sel),
        .illegal (dec_illegal)
    );

    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign accept  = in_valid && in_ready;
    assign issue   = out_valid && out_ready;

    always_comb begin
        new_entry.in1     = rs1_val;
        new_entry.in2     = dec_imm_sel ? imm_ext : rs2_val;
        new_entry.crtlSig = dec_crtl;
        new_entry.illegal = dec_illegal;
    end

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (issue) begin
            // in_ready is low whenever skid is full, so accept cannot coincide with a skid refill.
            if (skid_full_q) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d = new_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_valid) begin
                skid_d      = new_entry;
                skid_full_d = 1'b1;
            end else begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid   <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid   <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready    <= !skid_full_d;
        end
    end

    assign in1     = out_q.in1;
    assign in2     = out_q.in2;
    assign crtlSig = out_q.crtlSig;
    assign illegal = out_q.illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
